// File: rtl/arb_out_buffer.sv
// FWFT output buffer between the readout arbiter and the board FIFO; words dropped while full are
// counted and replaced by one overflow marker. Define ARB_OUT_BUFFER_STATS_EN for WORD_CNT/MAX_OCC.
module arb_out_buffer #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned NEAR_FULL_THR = 12,
    parameter logic [7:0]  MARKER_ID     = 8'hF0
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST,
    input  logic                     WRITE_IN,
    input  logic [31:0]              DATA_IN,
    output logic                     READY_OUT,
    input  logic                     FIFO_READ,
    output logic                     FIFO_EMPTY,
    output logic [31:0]              FIFO_DATA,
    output logic                     FIFO_NEAR_FULL,
    output logic                     OVERFLOW_FLAG,
    output logic [31:0]              WORD_CNT,
    output logic [$clog2(DEPTH):0]   MAX_OCC
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] THR  = CW'(NEAR_FULL_THR);

    typedef enum logic {IDLE, LOST} state_t;

    state_t        state, state_nxt;
    logic [23:0]   lost, lost_nxt, lost_eff;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   push_data;
    logic          push, pop, ready, set_ovf;
    logic          near_full, ovf;

    assign ready          = (state == IDLE) && (cnt < FULL);
    assign READY_OUT      = ready && !BUS_RST;
    assign pop            = FIFO_READ && (cnt != '0);
    assign FIFO_EMPTY     = (cnt == '0);
    assign FIFO_DATA      = (cnt == '0) ? '0 : mem[rd_ptr];
    assign FIFO_NEAR_FULL = near_full;
    assign OVERFLOW_FLAG  = ovf;

    always_comb begin
        state_nxt = state;
        lost_nxt  = lost;
        push      = 1'b0;
        push_data = DATA_IN;
        set_ovf   = 1'b0;
        lost_eff  = (WRITE_IN && lost != '1) ? lost + 24'd1 : lost;
        case (state)
            IDLE: begin
                if (WRITE_IN) begin
                    if (ready) begin
                        push = 1'b1;
                    end else begin
                        lost_nxt  = 24'd1;
                        set_ovf   = 1'b1;
                        state_nxt = LOST;
                    end
                end
            end
            LOST: begin
                // Marker is emitted only once the registered count shows room; any write in that cycle is folded into it.
                if (cnt == FULL) begin
                    lost_nxt = lost_eff;
                end else begin
                    push      = 1'b1;
                    push_data = {MARKER_ID, lost_eff};
                    lost_nxt  = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop)
            cnt_nxt = cnt + 1'b1;
        else if (pop && !push)
            cnt_nxt = cnt - 1'b1;
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state     <= IDLE;
            lost      <= '0;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            near_full <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_nxt;
            lost      <= lost_nxt;
            cnt       <= cnt_nxt;
            near_full <= (cnt_nxt >= THR);
            if (set_ovf)
                ovf <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

`ifdef ARB_OUT_BUFFER_STATS_EN
    logic [31:0]   word_cnt;
    logic [CW-1:0] max_occ;

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            word_cnt <= '0;
            max_occ  <= '0;
        end else begin
            if (pop)
                word_cnt <= word_cnt + 32'd1;
            if (cnt_nxt > max_occ)
                max_occ <= cnt_nxt;
        end
    end

    assign WORD_CNT = word_cnt;
    assign MAX_OCC  = max_occ;
`else
    assign WORD_CNT = '0;
    assign MAX_OCC  = '0;
`endif

endmodule

// File: tb/tb_arb_out_buffer.sv
// Directed bench for arb_out_buffer (DEPTH=16): fill/drain, overflow markers, same-cycle cases,
// steady streaming and reset while dropping.
module tb_arb_out_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_in = 1'b0;
    logic [31:0] data_in = '0;
    logic        fifo_read = 1'b0;
    logic        ready, empty, near_full, ovf;
    logic [31:0] data, word_cnt;
    logic [4:0]  max_occ;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] q[$];

    arb_out_buffer #(.DEPTH(16), .NEAR_FULL_THR(12), .MARKER_ID(8'hF0)) dut (
        .BUS_CLK(clk), .BUS_RST(rst), .WRITE_IN(write_in), .DATA_IN(data_in),
        .READY_OUT(ready), .FIFO_READ(fifo_read), .FIFO_EMPTY(empty), .FIFO_DATA(data),
        .FIFO_NEAR_FULL(near_full), .OVERFLOW_FLAG(ovf), .WORD_CNT(word_cnt), .MAX_OCC(max_occ)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_data"}, data, 0);
        chk({tag, "_nf"}, near_full, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_wcnt"}, word_cnt, 0);
        chk({tag, "_maxocc"}, max_occ, 0);
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            write_in = 1'b1;
            data_in  = base + 32'(i);
            tick;
            chk("fill_empty", empty, 0);
            chk("fill_head", data, base);
            chk("fill_nf", near_full, (i + 1 >= 12));
            chk("fill_ready", ready, (i + 1 < 16));
        end
        write_in = 1'b0;
    endtask

    task automatic drain(input logic [31:0] base, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            chk("drain_data", data, base + 32'(i));
            fifo_read = 1'b1;
            tick;
        end
        fifo_read = 1'b0;
    endtask

    task automatic drop_writes(input int n);
        for (int i = 0; i < n; i++) begin
            write_in = 1'b1;
            data_in  = 32'hDEAD_0000 + 32'(i);
            tick;
            chk("drop_ovf", ovf, 1);
            chk("drop_ready", ready, 0);
        end
        write_in = 1'b0;
    endtask

    initial begin
        // reset values
        #2;
        check_reset_outputs("rst0");
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("rst_release_ready", ready, 1);

        // fill 0..15 then drain in order
        fill(32'h0, 16);
        chk("full_ready", ready, 0);
        drain(32'h0, 0, 15);
        chk("drain1_empty", empty, 1);
        chk("drain1_data0", data, 0);
`ifdef ARB_OUT_BUFFER_STATS_EN
        chk("stats1_wcnt", word_cnt, 16);
        chk("stats1_maxocc", max_occ, 16);
`else
        chk("stats1_wcnt", word_cnt, 0);
        chk("stats1_maxocc", max_occ, 0);
`endif

        // three drops, marker 0xF0000003
        fill(32'h100, 16);
        drop_writes(3);
        fifo_read = 1'b1;
        chk("ovf3_head", data, 32'h100);
        tick;
        chk("ovf3_ready_lost", ready, 0);
        chk("ovf3_head2", data, 32'h101);
        tick;
        fifo_read = 1'b0;
        chk("ovf3_ready_back", ready, 1);
        drain(32'h100, 2, 15);
        chk("ovf3_marker", data, 32'hF000_0003);
        fifo_read = 1'b1;
        tick;
        fifo_read = 1'b0;
        chk("ovf3_empty", empty, 1);
        chk("ovf3_sticky", ovf, 1);

        // three drops plus a write in the marker cycle, marker 0xF0000004
        fill(32'h200, 16);
        drop_writes(3);
        fifo_read = 1'b1;
        tick;
        write_in = 1'b1;
        data_in  = 32'hBEEF_BEEF;
        tick;
        write_in  = 1'b0;
        fifo_read = 1'b0;
        chk("ovf4_ready_back", ready, 1);
        drain(32'h200, 2, 15);
        chk("ovf4_marker", data, 32'hF000_0004);
        fifo_read = 1'b1;
        tick;
        fifo_read = 1'b0;
        chk("ovf4_empty", empty, 1);

        // write + read on empty FIFO: the read is ignored
        write_in  = 1'b1;
        data_in   = 32'hA5A5_0001;
        fifo_read = 1'b1;
        tick;
        write_in  = 1'b0;
        fifo_read = 1'b0;
        chk("wr_rd_empty_empty", empty, 0);
        chk("wr_rd_empty_data", data, 32'hA5A5_0001);
        fifo_read = 1'b1;
        tick;
        fifo_read = 1'b0;
        chk("wr_rd_empty_drained", empty, 1);

        // reset while dropping: buffered words and pending marker are discarded
        fill(32'h500, 16);
        drop_writes(1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_lost");
        tick;
        rst = 1'b0;
        #1;
        chk("rst_lost_ready", ready, 1);
        chk("rst_lost_empty", empty, 1);

        // cnt held at 8 by 100 cycles of push+pop
        for (int i = 0; i < 8; i++) q.push_back(32'h300 + 32'(i));
        fill(32'h300, 8);
        for (int k = 0; k < 100; k++) begin
            write_in  = 1'b1;
            data_in   = 32'h400 + 32'(k);
            fifo_read = 1'b1;
            chk("stream_head", data, q[0]);
            void'(q.pop_front());
            q.push_back(data_in);
            tick;
        end
        write_in  = 1'b0;
        fifo_read = 1'b0;
        chk("stream_nf", near_full, 0);
        chk("stream_ready", ready, 1);
`ifdef ARB_OUT_BUFFER_STATS_EN
        chk("stream_wcnt", word_cnt, 100);
        chk("stream_maxocc", max_occ, 8);
`else
        chk("stream_wcnt", word_cnt, 0);
        chk("stream_maxocc", max_occ, 0);
`endif
        for (int i = 0; i < 8; i++) begin
            chk("stream_drain", data, q[0]);
            void'(q.pop_front());
            fifo_read = 1'b1;
            tick;
        end
        fifo_read = 1'b0;
        chk("stream_final_empty", empty, 1);
        chk("stream_no_ovf", ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
